// File: rtl/bb_uart_rx.sv
// bb_uart_rx: 8N1 UART receiver sampling rxd with an OVS-times oversampled baud clock.
// Latency: rxrdy rises about 2 + 1 + OVS/2 + 9*OVS bdclk edges after rxd first goes low.
// Backpressure: the byte is held until rxrd; a frame completing while rxrdy=1 is dropped and flagged ovr.
//
// Ports:
//   bdclk  oversampled baud clock (OVS x baud)
//   rst    asynchronous active-low reset
//   rxd    asynchronous serial input, idle high
//   rxrd   one-cycle read acknowledge; clears rxrdy, ferr, ovr
//   rxreg  last correctly received byte
//   rxrdy  rxreg holds an unread byte
//   rxbsy  frame reception in progress
//   ferr   framing error (sticky until rxrd)
//   ovr    overrun (sticky until rxrd)
//
// Optional build macro: BB_UART_RX_MAJORITY_EN -- sample points use a 2-of-3
// majority over the last three synchronized rxd values.
module bb_uart_rx #(
  parameter int OVS = 16,
  parameter int CW  = 4
) (
  input  logic       bdclk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rxrd,
  output logic [7:0] rxreg,
  output logic       rxrdy,
  output logic       rxbsy,
  output logic       ferr,
  output logic       ovr
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITH} state_t;

  localparam logic [CW-1:0] CNT_HALF = CW'(OVS/2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bidx, bidx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic [7:0]    rxreg_nx;
  logic          rxrdy_nx, ferr_nx, ovr_nx;
  logic          rxd_m, rxd_s;
  logic          smp;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge bdclk or negedge rst) begin
    if (!rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

`ifdef BB_UART_RX_MAJORITY_EN
  logic [2:0] hist;

  always_ff @(posedge bdclk or negedge rst) begin
    if (!rst) hist <= 3'b111;
    else      hist <= {hist[1:0], rxd_s};
  end

  // A single-cycle glitch can only flip one of the three votes.
  assign smp = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
  assign smp = rxd_s;
`endif

  always_ff @(posedge bdclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bidx_nx  = bidx;
    shreg_nx = shreg;
    rxreg_nx = rxreg;
    rxrdy_nx = rxrdy;
    ferr_nx  = ferr;
    ovr_nx   = ovr;

    // Acknowledge first; any flag set below in the same cycle overrides it.
    if (rxrd) begin
      rxrdy_nx = 1'b0;
      ferr_nx  = 1'b0;
      ovr_nx   = 1'b0;
    end

    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          if (smp) begin
            state_nx = IDLE;            // false start: no flags
          end else begin
            state_nx = DATA;
            cnt_nx   = '0;
            bidx_nx  = '0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shreg_nx = {smp, shreg[7:1]};  // LSB arrives first
          cnt_nx   = '0;
          bidx_nx  = bidx + 3'd1;
          if (bidx == 3'd7) state_nx = STOP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nx = '0;
          if (smp) begin
            state_nx = IDLE;
            // A same-cycle rxrd frees the register, so the store wins.
            if (rxrdy && !rxrd) begin
              ovr_nx = 1'b1;
            end else begin
              rxreg_nx = shreg;
              rxrdy_nx = 1'b1;
            end
          end else begin
            ferr_nx  = 1'b1;
            state_nx = WAITH;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAITH: begin
        // A break is reported once; wait for the line to return high.
        if (rxd_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge bdclk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      bidx  <= '0;
      shreg <= '0;
      rxreg <= '0;
      rxrdy <= 1'b0;
      rxbsy <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      cnt   <= cnt_nx;
      bidx  <= bidx_nx;
      shreg <= shreg_nx;
      rxreg <= rxreg_nx;
      rxrdy <= rxrdy_nx;
      rxbsy <= (state_nx != IDLE);
      ferr  <= ferr_nx;
      ovr   <= ovr_nx;
    end
  end

endmodule

// File: tb/tb_bb_uart_rx.sv
// tb_bb_uart_rx: scoreboard bench for bb_uart_rx at OVS=16.
// Stimulus is driven on the falling edge; outputs are sampled on the falling edge.
// Expected bytes are queued when a frame is sent and popped when the receiver stores one.
module tb_bb_uart_rx;

  localparam int OVS = 16;

  logic       bdclk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rxrd;
  logic [7:0] rxreg;
  logic       rxrdy, rxbsy, ferr, ovr;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  int         frm_start = 0;
  int         ferr_rises = 0;
  logic [7:0] sb[$];
  logic       prev_rdy = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] prev_reg = 8'h00;
  logic       saw_bsy;

  bb_uart_rx #(.OVS(OVS), .CW(4)) dut (
    .bdclk (bdclk),
    .rst   (rst),
    .rxd   (rxd),
    .rxrd  (rxrd),
    .rxreg (rxreg),
    .rxrdy (rxrdy),
    .rxbsy (rxbsy),
    .ferr  (ferr),
    .ovr   (ovr)
  );

  always #5 bdclk = ~bdclk;
  always @(posedge bdclk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stopb);
    logic [9:0] bits;
    bits = {stopb, d, 1'b0};
    frm_start = cyc;
    for (int b = 0; b < 10; b++) begin
      rxd = bits[b];
      repeat (OVS) @(negedge bdclk);
    end
  endtask

  task automatic pulse_rxrd();
    rxrd = 1'b1;
    @(negedge bdclk);
    rxrd = 1'b0;
    @(negedge bdclk);
  endtask

  // A store shows up as rxrdy rising or rxreg changing while rxrdy stays high.
  always @(negedge bdclk) begin
    int         lat;
    logic [7:0] exp_b;
    if (rst) begin
      if (ferr && !prev_ferr) ferr_rises++;
      if (rxrdy && (!prev_rdy || rxreg != prev_reg)) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_store", sb.size(), 1);
        end else begin
          exp_b = sb.pop_front();
          check("sb_byte", {24'h0, rxreg}, {24'h0, exp_b});
          lat = cyc - frm_start - 1;
          check("sb_latency_154_156", {31'h0, (lat >= 154 && lat <= 156)}, 1);
        end
      end
    end
    prev_rdy  = rxrdy;
    prev_ferr = ferr;
    prev_reg  = rxreg;
  end

  initial begin
    rst  = 1'b0;
    rxd  = 1'b1;
    rxrd = 1'b0;
    repeat (3) @(negedge bdclk);
    check("rst_rxreg", {24'h0, rxreg}, 0);
    check("rst_rxrdy", rxrdy, 0);
    check("rst_rxbsy", rxbsy, 0);
    check("rst_ferr",  ferr,  0);
    check("rst_ovr",   ovr,   0);
    rst = 1'b1;
    repeat (5) @(negedge bdclk);

    // Basic byte, then acknowledge.
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (4) @(negedge bdclk);
    check("a5_rxreg", {24'h0, rxreg}, 32'hA5);
    check("a5_rxrdy", rxrdy, 1);
    check("a5_ferr",  ferr,  0);
    check("a5_ovr",   ovr,   0);
    rxrd = 1'b1;
    @(negedge bdclk);
    rxrd = 1'b0;
    check("a5_rxrd_clears", rxrdy, 0);
    repeat (4) @(negedge bdclk);

    // False start: 4-cycle low glitch.
    saw_bsy = 1'b0;
    rxd = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge bdclk);
      if (i == 3) rxd = 1'b1;
      if (rxbsy) saw_bsy = 1'b1;
    end
    check("fs_bsy_seen",  saw_bsy, 1);
    check("fs_bsy_idle",  rxbsy, 0);
    check("fs_rxrdy",     rxrdy, 0);
    check("fs_ferr",      ferr,  0);
    check("fs_rxreg",     {24'h0, rxreg}, 32'hA5);

    // Framing error followed by a 40-bit break.
    ferr_rises = 0;
    send_frame(8'h3C, 1'b0);
    repeat (40 * OVS) @(negedge bdclk);
    rxd = 1'b1;
    repeat (2 * OVS) @(negedge bdclk);
    check("fe_ferr",      ferr, 1);
    check("fe_once",      ferr_rises, 1);
    check("fe_rxrdy",     rxrdy, 0);
    check("fe_rxreg",     {24'h0, rxreg}, 32'hA5);
    check("fe_bsy",       rxbsy, 0);
    pulse_rxrd();
    check("fe_cleared",   ferr, 0);
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (4) @(negedge bdclk);
    check("fe_next_rxreg", {24'h0, rxreg}, 32'h81);
    check("fe_next_rxrdy", rxrdy, 1);
    pulse_rxrd();

    // Overrun: second byte is dropped.
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge bdclk);
    check("ov_rxreg", {24'h0, rxreg}, 32'h11);
    check("ov_ovr",   ovr, 1);
    check("ov_rxrdy", rxrdy, 1);
    pulse_rxrd();
    check("ov_clr_rxrdy", rxrdy, 0);
    check("ov_clr_ovr",   ovr, 0);
    check("ov_clr_ferr",  ferr, 0);
    repeat (4) @(negedge bdclk);

    // Back-to-back frames; rxrd lands on edge 154 of the second frame (its store).
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        repeat (160 + 154) @(negedge bdclk);
        rxrd = 1'b1;
        @(negedge bdclk);
        rxrd = 1'b0;
      end
    join
    repeat (4) @(negedge bdclk);
    check("bb_rxreg", {24'h0, rxreg}, 32'hFF);
    check("bb_rxrdy", rxrdy, 1);
    check("bb_ovr",   ovr, 0);

    // Reset during data bit 4 of 0x5A (rxrdy/rxreg still hold 0xFF).
    fork
      send_frame(8'h5A, 1'b1);
      begin
        repeat (5 * OVS + OVS / 2) @(negedge bdclk);
        check("mr_bsy_before", rxbsy, 1);
        rst = 1'b0;
        #1;
        check("mr_rxreg", {24'h0, rxreg}, 0);
        check("mr_rxrdy", rxrdy, 0);
        check("mr_rxbsy", rxbsy, 0);
        check("mr_ferr",  ferr, 0);
        check("mr_ovr",   ovr, 0);
      end
    join
    repeat (4) @(negedge bdclk);
    rst = 1'b1;
    repeat (20) @(negedge bdclk);
    check("mr_after_rxrdy", rxrdy, 0);
    check("mr_after_bsy",   rxbsy, 0);
    sb.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    repeat (4) @(negedge bdclk);
    check("mr_96_rxreg", {24'h0, rxreg}, 32'h96);
    check("mr_96_rxrdy", rxrdy, 1);
    repeat (OVS) @(negedge bdclk);

    check("sb_empty_at_end", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
